// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe
//  Description : Parametrised ALU with valid/ready handshakes on the operand
//                and result sides. Single-cycle logic/arithmetic ops plus a
//                multi-cycle radix-2 shift-add multiply. One operation in
//                flight at a time; each result carries {Z,N,C,V} flags.
//  Ports       : ck, rst            - clock, synchronous active-high reset
//                in_valid/in_ready  - operand handshake (A, B, CTR)
//                A, B [WIDTH]       - operands
//                CTR  [4]           - opcode
//                out_valid/out_ready- result handshake (O, FLAGS)
//                O    [WIDTH]       - result
//                FLAGS[4]           - {Z,N,C,V}
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       CTR,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] O,
    output logic [3:0]       FLAGS
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_MUL  = 2'd2;
    localparam logic [1:0] c_HOLD = 2'd3;

    localparam logic [3:0] c_OP_ADD = 4'b0000;
    localparam logic [3:0] c_OP_SUB = 4'b0001;
    localparam logic [3:0] c_OP_MUL = 4'b0010;
    localparam logic [3:0] c_OP_AND = 4'b1000;
    localparam logic [3:0] c_OP_OR  = 4'b1001;
    localparam logic [3:0] c_OP_XOR = 4'b1010;
    localparam logic [3:0] c_OP_NOT = 4'b1011;
    localparam logic [3:0] c_OP_SRL = 4'b1100;
    localparam logic [3:0] c_OP_SLL = 4'b1101;
    localparam logic [3:0] c_OP_ROR = 4'b1110;
    localparam logic [3:0] c_OP_ROL = 4'b1111;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [3:0]         r_ctr;
    logic [2*WIDTH-1:0] r_prod;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_o;
    logic [3:0]         r_flags;

    logic               w_accept;
    logic               w_mul_last;

    assign w_accept   = in_valid & in_ready;
    assign w_mul_last = (r_cnt == c_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge ck) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (CTR == c_OP_MUL) ? c_MUL : c_EXEC;
                end
            end
            c_EXEC: begin
                w_state_nxt = c_HOLD;
            end
            c_MUL: begin
                if (w_mul_last) begin
                    w_state_nxt = c_HOLD;
                end
            end
            c_HOLD: begin
                // An accept in HOLD implies out_ready, so the pending
                // result is consumed in the same cycle.
                if (w_accept) begin
                    w_state_nxt = (CTR == c_OP_MUL) ? c_MUL : c_EXEC;
                end else if (out_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (in_ready deliberately independent of in_valid)
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            c_IDLE: in_ready = 1'b1;
            c_HOLD: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Single-cycle ALU on the latched operands
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic             w_undef;
    logic [3:0]       w_alu_flags;

    assign w_add = {1'b0, r_a} + {1'b0, r_b};
    // Bit WIDTH of the zero-extended difference is the unsigned borrow.
    assign w_sub = {1'b0, r_a} - {1'b0, r_b};

    always_comb begin
        w_res   = '0;
        w_c     = 1'b0;
        w_v     = 1'b0;
        w_undef = 1'b0;
        case (r_ctr)
            c_OP_ADD: begin
                w_res = w_add[WIDTH-1:0];
                w_c   = w_add[WIDTH];
                w_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                        (w_add[WIDTH-1] != r_a[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_res = w_sub[WIDTH-1:0];
                w_c   = w_sub[WIDTH];
                w_v   = (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                        (w_sub[WIDTH-1] != r_a[WIDTH-1]);
            end
            c_OP_AND: w_res = r_a & r_b;
            c_OP_OR:  w_res = r_a | r_b;
            c_OP_XOR: w_res = r_a ^ r_b;
            c_OP_NOT: w_res = ~r_a;
            c_OP_SRL: begin
                w_res = {1'b0, r_a[WIDTH-1:1]};
                w_c   = r_a[0];
            end
            c_OP_SLL: begin
                w_res = {r_a[WIDTH-2:0], 1'b0};
                w_c   = r_a[WIDTH-1];
            end
            c_OP_ROR: begin
                w_res = {r_a[0], r_a[WIDTH-1:1]};
                w_c   = r_a[0];
            end
            c_OP_ROL: begin
                w_res = {r_a[WIDTH-2:0], r_a[WIDTH-1]};
                w_c   = r_a[WIDTH-1];
            end
            default: w_undef = 1'b1;
        endcase
    end

    // Undefined opcodes fall through with w_res=0, so Z=1 and N=C=V=0.
    assign w_alu_flags = {(w_res == '0), w_res[WIDTH-1], w_c & ~w_undef, w_v & ~w_undef};

    // ------------------------------------------------------------------
    // Shift-add multiply step: conditionally add a into the upper half
    // (keeping the carry) and shift the whole product right by one.
    // The multiplier b starts in the lower half and is consumed LSB-first.
    // ------------------------------------------------------------------
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_prod_nxt;
    logic [3:0]         w_mul_flags;

    assign w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} +
                        (r_prod[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    assign w_prod_nxt = {w_mul_sum, r_prod[WIDTH-1:1]};
    assign w_mul_flags = {(w_prod_nxt[WIDTH-1:0] == '0),
                          w_prod_nxt[WIDTH-1],
                          (w_prod_nxt[2*WIDTH-1:WIDTH] != '0),
                          1'b0};

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge ck) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_ctr   <= '0;
            r_prod  <= '0;
            r_cnt   <= '0;
            r_o     <= '0;
            r_flags <= '0;
        end else begin
            if (w_accept) begin
                r_a    <= A;
                r_b    <= B;
                r_ctr  <= CTR;
                r_prod <= {{WIDTH{1'b0}}, B};
                r_cnt  <= '0;
            end
            case (r_state)
                c_EXEC: begin
                    r_o     <= w_res;
                    r_flags <= w_alu_flags;
                end
                c_MUL: begin
                    r_prod <= w_prod_nxt;
                    r_cnt  <= r_cnt + c_CNT_W'(1);
                    if (w_mul_last) begin
                        r_o     <= w_prod_nxt[WIDTH-1:0];
                        r_flags <= w_mul_flags;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign O     = r_o;
    assign FLAGS = r_flags;

endmodule
`default_nettype wire
